// File: rtl/pcileech_board_ctl.sv
// ============================================================================
//  Module   : pcileech_board_ctl
//  Brief    : Board reset sequencer, user-switch debounce, config-reload
//             long-press detector and power-on LED blink for Artix-7 PCILeech.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pcileech_board_ctl_debounce #(
   parameter int unsigned PARAM_DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run_i,
   input  logic sw_ni,
   output logic sw_p_o
);

   localparam logic [31:0] c_last = 32'(PARAM_DEBOUNCE_CYCLES - 1);

   logic [1:0]  sync_q;
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;
   logic        sw_p_q;
   logic        sw_p_d;
   logic        w_sample;

   // Switch is active low; the sample is the "pressed" level.
   assign w_sample = ~sync_q[1];

   always_comb begin
      cnt_d  = cnt_q;
      sw_p_d = sw_p_q;
      if (w_sample == sw_p_q) begin
         cnt_d = '0;
      end else if (cnt_q == c_last) begin
         sw_p_d = w_sample;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
         sw_p_q <= 1'b0;
      end else if (run_i) begin
         sync_q <= {sync_q[0], sw_ni};
         cnt_q  <= cnt_d;
         sw_p_q <= sw_p_d;
      end
   end

   assign sw_p_o = sw_p_q;

endmodule

module pcileech_board_ctl #(
   parameter int unsigned PARAM_DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned PARAM_RST_HOLD_CYCLES = 64,
   parameter int unsigned PARAM_SYS_LAG_CYCLES  = 16,
   parameter int unsigned PARAM_RELOAD_CYCLES   = 500000000,
   parameter int unsigned PARAM_BLINK_BIT       = 24
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sw1_ni,
   input  logic sw2_ni,
   output logic rst_sys_o,
   output logic rst_com_no,
   output logic cfg_reload_o,
   output logic led_pwronblink_o
);

   localparam logic [31:0]      c_com_release = 32'(PARAM_RST_HOLD_CYCLES);
   localparam logic [31:0]      c_sys_release = 32'(PARAM_RST_HOLD_CYCLES + PARAM_SYS_LAG_CYCLES);
   localparam logic [31:0]      c_reload_last = 32'(PARAM_RELOAD_CYCLES - 1);
   localparam int unsigned      c_up_w        = PARAM_BLINK_BIT + 4;
   localparam logic [c_up_w-1:0] c_up_sat     = {1'b1, {(PARAM_BLINK_BIT + 3){1'b0}}};
   localparam logic [c_up_w-1:0] c_up_one     = c_up_w'(1);

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_HOLD     = 3'd1,
      S_RUN      = 3'd2,
      S_BTN      = 3'd3,
      S_WAIT_REL = 3'd4
   } state_t;

   // Reset synchronizer: async assert, release two edges after rst_ni rises.
   logic [1:0] rst_sync_q;
   logic       w_run;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign w_run = rst_sync_q[1];

   logic [1:0] w_sw_n;
   logic [1:0] w_sw_p;

   assign w_sw_n = {sw2_ni, sw1_ni};

   for (genvar gi = 0; gi < 2; gi++) begin : g_sw
      pcileech_board_ctl_debounce #(
         .PARAM_DEBOUNCE_CYCLES (PARAM_DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .run_i  (w_run),
         .sw_ni  (w_sw_n[gi]),
         .sw_p_o (w_sw_p[gi])
      );
   end

   logic w_sw1_p;
   logic w_sw2_p;
   logic w_sw2_rise;
   logic w_sw2_fall;

   assign w_sw1_p = w_sw_p[0];
   assign w_sw2_p = w_sw_p[1];

   state_t      state_q;
   logic [31:0] cnt_q;
   logic [31:0] w_cnt_inc;
   logic        sw2_prev_q;
   logic        rst_sys_q;
   logic        rst_com_n_q;
   logic        cfg_reload_q;

   // Edges are taken against the previous debounced level, so every FSM
   // reaction lands one edge after the debounced change.
   assign w_sw2_rise = w_sw2_p & ~sw2_prev_q;
   assign w_sw2_fall = ~w_sw2_p & sw2_prev_q;
   assign w_cnt_inc  = cnt_q + 32'd1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_RESET;
         cnt_q        <= '0;
         sw2_prev_q   <= 1'b0;
         rst_sys_q    <= 1'b1;
         rst_com_n_q  <= 1'b0;
         cfg_reload_q <= 1'b0;
      end else if (w_run) begin
         sw2_prev_q   <= w_sw2_p;
         cfg_reload_q <= 1'b0;
         case (state_q)
            S_RESET: begin
               state_q <= S_HOLD;
               cnt_q   <= '0;
            end
            S_HOLD: begin
               if (w_sw2_rise) begin
                  state_q     <= S_BTN;
                  cnt_q       <= '0;
                  rst_sys_q   <= 1'b1;
                  rst_com_n_q <= 1'b0;
               end else begin
                  cnt_q <= w_cnt_inc;
                  if (w_cnt_inc >= c_com_release) begin
                     rst_com_n_q <= 1'b1;
                  end
                  if (w_cnt_inc >= c_sys_release) begin
                     rst_sys_q <= 1'b0;
                     state_q   <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_sw2_rise) begin
                  state_q     <= S_BTN;
                  cnt_q       <= '0;
                  rst_sys_q   <= 1'b1;
                  rst_com_n_q <= 1'b0;
               end
            end
            S_BTN: begin
               if (cnt_q == c_reload_last) begin
                  cfg_reload_q <= 1'b1;
                  state_q      <= S_WAIT_REL;
               end else if (w_sw2_fall) begin
                  state_q <= S_HOLD;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= w_cnt_inc;
               end
            end
            S_WAIT_REL: begin
               if (w_sw2_fall) begin
                  state_q <= S_HOLD;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= S_RESET;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   logic [c_up_w-1:0] uptime_q;
   logic [c_up_w-1:0] uptime_d;
   logic              led_q;
   logic              led_d;

   always_comb begin
      uptime_d = uptime_q;
      if ((state_q == S_BTN) || (state_q == S_WAIT_REL)) begin
         uptime_d = '0;
      end else if (uptime_q < c_up_sat) begin
         uptime_d = uptime_q + c_up_one;
      end
   end

   // Blink only during the early uptime window; afterwards the LED follows SW1.
   assign led_d = w_sw1_p ^ (uptime_q[PARAM_BLINK_BIT] & (uptime_q < c_up_sat));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         uptime_q <= '0;
         led_q    <= 1'b0;
      end else if (w_run) begin
         uptime_q <= uptime_d;
         led_q    <= led_d;
      end
   end

   assign rst_sys_o        = rst_sys_q;
   assign rst_com_no       = rst_com_n_q;
   assign cfg_reload_o     = cfg_reload_q;
   assign led_pwronblink_o = led_q;

endmodule

`default_nettype wire

// File: tb/tb_pcileech_board_ctl.sv
// ============================================================================
//  Module   : tb_pcileech_board_ctl
//  Brief    : Directed self-checking bench for pcileech_board_ctl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pcileech_board_ctl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sw1_n = 1'b1;
   logic sw2_n = 1'b1;
   logic rst_sys;
   logic rst_com_n;
   logic cfg_reload;
   logic led;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pcileech_board_ctl #(
      .PARAM_DEBOUNCE_CYCLES (4),
      .PARAM_RST_HOLD_CYCLES (8),
      .PARAM_SYS_LAG_CYCLES  (4),
      .PARAM_RELOAD_CYCLES   (20),
      .PARAM_BLINK_BIT       (2)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .sw1_ni           (sw1_n),
      .sw2_ni           (sw2_n),
      .rst_sys_o        (rst_sys),
      .rst_com_no       (rst_com_n),
      .cfg_reload_o     (cfg_reload),
      .led_pwronblink_o (led)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called right after rst_n rises; k counts edges from the RESET->HOLD edge.
   task automatic run_release(input string tag, input int n);
      tick(2);
      chk({tag, "_sync_com"}, rst_com_n, 1'b0);
      chk({tag, "_sync_sys"}, rst_sys, 1'b1);
      for (int k = 0; k < n; k++) begin
         tick(1);
         chk($sformatf("%s_com_c%0d", tag, k), rst_com_n, k >= 8);
         chk($sformatf("%s_sys_c%0d", tag, k), rst_sys, k < 12);
         chk($sformatf("%s_cfg_c%0d", tag, k), cfg_reload, 1'b0);
         chk($sformatf("%s_led_c%0d", tag, k), led, (k < 32) ? k[2] : 1'b0);
      end
   endtask

   initial begin
      // Reset values
      tick(3);
      chk("rst_sys", rst_sys, 1'b1);
      chk("rst_com", rst_com_n, 1'b0);
      chk("rst_cfg", cfg_reload, 1'b0);
      chk("rst_led", led, 1'b0);

      // 1 + 5: release sequence with blink window 0..31, then steady 0
      rst_n = 1'b1;
      run_release("s1", 41);

      // 5: SW1 press inverts the LED after 2 + 4 edges
      sw1_n = 1'b0;
      tick(6);
      chk("s5_press_pre", led, 1'b0);
      tick(1);
      chk("s5_press", led, 1'b1);
      tick(5);
      chk("s5_hold", led, 1'b1);
      sw1_n = 1'b1;
      tick(6);
      chk("s5_rel_pre", led, 1'b1);
      tick(1);
      chk("s5_rel", led, 1'b0);

      // 2: 3-cycle SW2 glitch is filtered
      sw2_n = 1'b0;
      tick(3);
      sw2_n = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick(1);
         chk($sformatf("s2_sys_%0d", j), rst_sys, 1'b0);
         chk($sformatf("s2_com_%0d", j), rst_com_n, 1'b1);
      end

      // 3: short press -> resets on edge after sw2_p rise, no reload, re-sequence
      sw2_n = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         tick(1);
         chk($sformatf("s3p_sys_%0d", j), rst_sys, j >= 7);
         chk($sformatf("s3p_com_%0d", j), rst_com_n, j < 7);
         chk($sformatf("s3p_cfg_%0d", j), cfg_reload, 1'b0);
      end
      sw2_n = 1'b1;
      for (int j = 1; j <= 22; j++) begin
         tick(1);
         chk($sformatf("s3r_com_%0d", j), rst_com_n, j >= 15);
         chk($sformatf("s3r_sys_%0d", j), rst_sys, j < 19);
         chk($sformatf("s3r_cfg_%0d", j), cfg_reload, 1'b0);
      end

      // 4: long press -> single reload pulse 20 edges after BTN entry
      sw2_n = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         tick(1);
         chk($sformatf("s4p_cfg_%0d", j), cfg_reload, j == 27);
         chk($sformatf("s4p_com_%0d", j), rst_com_n, j < 7);
         chk($sformatf("s4p_sys_%0d", j), rst_sys, j >= 7);
      end
      sw2_n = 1'b1;
      for (int j = 1; j <= 22; j++) begin
         tick(1);
         chk($sformatf("s4r_cfg_%0d", j), cfg_reload, 1'b0);
         chk($sformatf("s4r_com_%0d", j), rst_com_n, j >= 15);
         chk($sformatf("s4r_sys_%0d", j), rst_sys, j < 19);
      end

      // 6a: async reset while in BTN (SW1 held so LED is 1 beforehand)
      sw1_n = 1'b0;
      sw2_n = 1'b0;
      tick(10);
      chk("s6a_pre_led", led, 1'b1);
      chk("s6a_pre_sys", rst_sys, 1'b1);
      chk("s6a_pre_com", rst_com_n, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6a_async_led", led, 1'b0);
      chk("s6a_async_sys", rst_sys, 1'b1);
      chk("s6a_async_com", rst_com_n, 1'b0);
      chk("s6a_async_cfg", cfg_reload, 1'b0);
      sw1_n = 1'b1;
      sw2_n = 1'b1;
      #1;
      rst_n = 1'b1;
      run_release("s6a", 10);

      // 6b: async reset while in HOLD with rst_com_n already released
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6b_async_com", rst_com_n, 1'b0);
      chk("s6b_async_sys", rst_sys, 1'b1);
      chk("s6b_async_cfg", cfg_reload, 1'b0);
      #1;
      rst_n = 1'b1;
      run_release("s6b", 20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pcileech_board_ctl.md
# pcileech_board_ctl

Board-level reset and user-button controller for the Artix-7 PCILeech top levels. It debounces the two user switches and sequences the reset release: the FT601 communication core is released first, and the FIFO/PCIe cores follow a fixed number of cycles later. It also issues a one-shot configuration-reload pulse after a long press of SW2 and generates the power-on LED blink. It replaces the free-running tick-count reset logic in the board top and drives `rst`, `ft601_rst_n`, `rst_cfg_reload` and `led_state_invert`.

## Interface
- PARAM_DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a switch change (10 ms at 100 MHz).
- PARAM_RST_HOLD_CYCLES, 64: cycles in HOLD before `rst_com_n` is released.
- PARAM_SYS_LAG_CYCLES, 16: additional cycles after `rst_com_n` release before `rst_sys` is released.
- PARAM_RELOAD_CYCLES, 500000000: debounced SW2 hold time that triggers `cfg_reload` (5 s).
- PARAM_BLINK_BIT, 24: uptime bit that drives the blink.
- clk  in  1  100 MHz system clock; all logic is in this domain.
- rst_n  in  1  asynchronous, active-low reset: asserted asynchronously, released synchronously through an internal 2-flop synchronizer.
- sw1_n  in  1  raw SW1, active low, asynchronous.
- sw2_n  in  1  raw SW2, active low, asynchronous.
- rst_sys  out  1  active-high reset to the FIFO and PCIe cores.
- rst_com_n  out  1  active-low reset to the FT601 core and pad.
- cfg_reload  out  1  one-cycle pulse requesting a configuration reload.
- led_pwronblink  out  1  LED invert control.

## Operation
- Synchronizers: `sw1_n` and `sw2_n` each pass through 2 flops.
- Debounce:
  - One counter per switch, 32 bits wide.
  - The counter clears whenever the synchronized sample equals the current debounced level.
  - When the counter reaches PARAM_DEBOUNCE_CYCLES−1 with the sample still differing, the debounced level flips and the counter clears.
  - Debounced pressed levels are named `sw1_p` and `sw2_p`; both reset to 0.
- FSM states: RESET, HOLD, RUN, BTN, WAIT_REL.
  - RESET → HOLD on the first clock with the internal reset released; the counter `cnt` clears.
  - HOLD: `cnt` increments every cycle.
    - `rst_com_n` = 1 once `cnt` ≥ PARAM_RST_HOLD_CYCLES.
    - `rst_sys` = 0 once `cnt` ≥ PARAM_RST_HOLD_CYCLES + PARAM_SYS_LAG_CYCLES; the FSM then enters RUN.
  - RUN: both resets are released. A rise of `sw2_p` → BTN.
  - BTN: `rst_sys` = 1 and `rst_com_n` = 0 on the next edge; `cnt` clears, then counts.
    - `sw2_p` falls before `cnt` reaches PARAM_RELOAD_CYCLES−1 → HOLD, with `cnt` cleared and no reload.
    - `cnt` reaches PARAM_RELOAD_CYCLES−1 → `cfg_reload` = 1 for exactly one cycle, then WAIT_REL.
  - WAIT_REL: resets stay asserted. A fall of `sw2_p` → HOLD with `cnt` cleared.
  - A rise of `sw2_p` while in HOLD → BTN (the sequence restarts).
- Uptime counter:
  - Width PARAM_BLINK_BIT+4.
  - Clears on reset and whenever the FSM is in BTN or WAIT_REL.
  - Otherwise increments, saturating at 2^(PARAM_BLINK_BIT+3).
- LED: `led_pwronblink` = `sw1_p` XOR (`uptime[PARAM_BLINK_BIT]` AND `uptime` < 2^(PARAM_BLINK_BIT+3)), registered.
- Reset mid-operation: `rst_n` low forces all state, counters and outputs to their reset values asynchronously, regardless of state.

## Timing
- Reset values:
  - `rst_sys` = 1, `rst_com_n` = 0, `cfg_reload` = 0, `led_pwronblink` = 0.
  - FSM = RESET; all counters = 0.
- Cycle numbering: cycle 0 is the first edge at which the FSM moves RESET → HOLD.
- `rst_com_n` rises at edge PARAM_RST_HOLD_CYCLES; `rst_sys` falls at edge PARAM_RST_HOLD_CYCLES + PARAM_SYS_LAG_CYCLES. Both are registered, with no glitches.
- Switch latency: 2 synchronizer cycles + PARAM_DEBOUNCE_CYCLES from a raw edge to the `sw*_p` change.
- Resets assert on the edge after `sw2_p` rises.
- `cfg_reload`: PARAM_RELOAD_CYCLES edges after entry to BTN. It is never re-issued within one press.
- Bounce shorter than PARAM_DEBOUNCE_CYCLES produces no `sw*_p` change.
- Simultaneous events: an `sw2_p` rise in the same cycle as the HOLD → RUN condition takes BTN.

## Test plan
Parameters for all scenarios: DEBOUNCE=4, RST_HOLD=8, SYS_LAG=4, RELOAD=20, BLINK_BIT=2.

1. Release `rst_n` → `rst_com_n` rises at cycle 8 and `rst_sys` falls at cycle 12. `cfg_reload` stays 0 throughout.
2. SW2 glitch low for 3 cycles during RUN → no `sw2_p` change and the resets stay released.
3. SW2 held for 10 cycles after debounce → `rst_sys` = 1 and `rst_com_n` = 0 on the edge after `sw2_p` rises. No `cfg_reload`. Re-sequencing gives 8/12-cycle releases after `sw2_p` falls.
4. SW2 held for 40 cycles → exactly one `cfg_reload` pulse, 20 cycles after BTN entry. Resets are held until release, then re-sequence.
5. Uptime check with SW1 released → `led_pwronblink` toggles every 4 cycles for uptime 0–31, then stays 0. Pressing SW1 (debounced) inverts it to 1.
6. `rst_n` pulsed low during BTN and during HOLD → outputs return to reset values immediately, without waiting for a clock, and the sequence of scenario 1 repeats.
